// File: rtl/seq_div_fsm.sv
// Sequential unsigned restoring divider: one quotient bit per clock over WIDTH
// clocks, with a registered one-cycle done pulse and a direct divide-by-zero path.
module seq_div_fsm #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic [1:0]       state
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    // Partial remainder is always below D, so its sign bit is never stored.
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] d_r;

    logic [WIDTH:0]   a_sh_s;
    logic [WIDTH:0]   t_s;
    logic [WIDTH-1:0] a_nxt_s;
    logic [WIDTH-1:0] q_nxt_s;

    assign state = state_r;

    // One restoring step: shift {A,Q}, trial-subtract D, restore on negative.
    always_comb begin
        a_sh_s = {a_r, q_r[WIDTH-1]};
        t_s    = a_sh_s - {1'b0, d_r};
        if (t_s[WIDTH]) begin
            a_nxt_s = a_sh_s[WIDTH-1:0];
            q_nxt_s = {q_r[WIDTH-2:0], 1'b0};
        end else begin
            a_nxt_s = t_s[WIDTH-1:0];
            q_nxt_s = {q_r[WIDTH-2:0], 1'b1};
        end
    end

    // Controller, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (areset) begin
            state_r     <= S_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            a_r         <= {WIDTH{1'b0}};
            q_r         <= {WIDTH{1'b0}};
            d_r         <= {WIDTH{1'b0}};
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= {WIDTH{1'b0}};
            remainder   <= {WIDTH{1'b0}};
            div_by_zero <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start && (divisor != {WIDTH{1'b0}})) begin
                        q_r         <= dividend;
                        d_r         <= divisor;
                        a_r         <= {WIDTH{1'b0}};
                        cnt_r       <= {CNT_W{1'b0}};
                        div_by_zero <= 1'b0;
                        busy        <= 1'b1;
                        state_r     <= S_EXEC;
                    end else if (start) begin
                        quotient    <= {WIDTH{1'b1}};
                        remainder   <= dividend;
                        div_by_zero <= 1'b1;
                        done        <= 1'b1;
                        busy        <= 1'b1;
                        state_r     <= S_DONE;
                    end else begin
                        busy    <= 1'b0;
                        state_r <= S_IDLE;
                    end
                end
                S_EXEC: begin
                    a_r   <= a_nxt_s;
                    q_r   <= q_nxt_s;
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (cnt_r == LAST_CNT) begin
                        quotient  <= q_nxt_s;
                        remainder <= a_nxt_s;
                        done      <= 1'b1;
                        state_r   <= S_DONE;
                    end else begin
                        state_r <= S_EXEC;
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/seq_div_fsm.md
Name: seq_div_fsm

Overview:
- Sequential unsigned restoring divider. It is the inverse-direction companion to the team's shift-add multiplier controller.
- Controller and datapath live in one block.
- Accepts dividend/divisor on a start pulse and performs one restoring step per clock for WIDTH clocks.
- Presents quotient/remainder with a one-cycle done pulse. Sits beside the multiplier in the arithmetic lab datapath.

Parameters:
WIDTH, 8, operand/quotient/remainder width in bits (>=2)

Ports:
clk  input  1  rising-edge clock
areset  input  1  synchronous active-high reset, sampled on posedge clk
start  input  1  request; sampled only in IDLE
dividend  input  WIDTH  numerator, captured when start accepted
divisor  input  WIDTH  denominator, captured when start accepted
busy  output  1  high in EXEC and DONE states
done  output  1  one-cycle pulse, results valid from this cycle
quotient  output  WIDTH  result quotient, held until next accepted start
remainder  output  WIDTH  result remainder, held until next accepted start
div_by_zero  output  1  set with done when captured divisor==0, held with results
state  output  2  current state encoding, for debug/lab display

Behaviour:
- Reset (areset=1 at posedge):
  - state=IDLE; busy=0, done=0.
  - quotient=0, remainder=0, div_by_zero=0, internal counter=0.
  - Reset wins over every other input, including mid-operation.
- State encoding: IDLE=0, EXEC=1, DONE=2. Value 3 is unused; if reached, go to IDLE next cycle.
- IDLE:
  - start=1 and divisor!=0 → capture Q=dividend, D=divisor, A=0 (WIDTH+1 bits); counter=0; clear div_by_zero; go EXEC.
  - start=1 and divisor==0 → go DONE directly with quotient={WIDTH{1}}, remainder=dividend, div_by_zero=1.
  - start=0 → stay IDLE; outputs hold.
- EXEC, one step per cycle:
  - shift {A,Q} left 1.
  - T = A - {1'b0,D}.
  - If T[WIDTH]==1 (negative): Q[0]=0, A unchanged. Otherwise Q[0]=1, A=T.
  - counter++. After the step where counter reaches WIDTH-1 → DONE.
- DONE:
  - done=1 for exactly this cycle; quotient=Q, remainder=A[WIDTH-1:0]. Results are registered on entry so they are valid while done=1.
  - Next state is always IDLE.
- Latency: start accepted at edge 0 → EXEC at edges 1..WIDTH → done high in the cycle after edge WIDTH (WIDTH+1 cycles from start). Divide-by-zero: done one cycle after start.
- start while busy (EXEC or DONE) is ignored, not queued. A new start is accepted only once back in IDLE, so back-to-back ops are WIDTH+2 cycles apart.
- Operands may change after capture without effect.
- Reset during EXEC aborts: no done pulse; outputs cleared.
- Results satisfy dividend == quotient*divisor + remainder with remainder < divisor for all divisor!=0.

Test Plan:
- Basic: reset, then start with dividend=100, divisor=7 → busy for 9 cycles; done pulses once 9 cycles after start edge; quotient=14, remainder=2, div_by_zero=0.
- Edge values: 255/1 → q=255, r=0. 5/10 → q=0, r=5. 0/3 → q=0, r=0. 255/255 → q=1, r=0.
- Divide by zero: 37/0 → done one cycle after start; q=255, r=37, div_by_zero=1. A following 20/4 → q=5, r=0, div_by_zero cleared.
- Ignored start: start 200/9, pulse start with 50/5 at cycle 3 and in the DONE cycle → single done; q=22, r=2; state returns IDLE.
- Reset mid-op: start 100/7, assert areset at cycle 4 → next cycle state=0, busy=0, q=r=0; no done pulse; new start 9/2 → q=4, r=1.
- Random sweep: 1000 random WIDTH=8 operand pairs (divisor!=0) checked against a reference model; done count equals accepted start count.
